// File: rtl/au_pkg.sv
// Shared types and constants for the nibble-serial add/sub engine.
// Holds the sequencer state encoding, opcode values and the slice width.
package au_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } au_state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int NIBBLE_W = 4;

   // Two's-complement overflow rule shared by the sequencer.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic op,
                                       input logic res_msb);
      return (a_msb == (b_msb ^ op)) && (res_msb != a_msb);
   endfunction

endpackage

// File: rtl/add_sub_4b.sv
// 4-bit carry-lookahead add/subtract slice.
// ctrl = 1 inverts b; the +1 of two's-complement subtraction enters through cin.
module add_sub_4b
   import au_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   input  logic                ctrl,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W-1:0] b_eff;
   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W:0]   c;

   assign b_eff = b ^ {NIBBLE_W{ctrl}};
   assign g     = a & b_eff;
   assign p     = a ^ b_eff;

   // Flattened lookahead carries: every carry depends only on g, p and cin.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[NIBBLE_W-1:0];
   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/sub: one nibble per cycle through a 4-bit CLA slice.
// Define AU_SAT_EN to clamp overflowing results to the signed limit.
module nibble_serial_addsub
   import au_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf,
   output logic             zero,
   output logic             busy
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
         $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   // Handshake: a transfer happens on an edge where valid and ready are both
   // high; in_ready is high only in IDLE, out_valid only in DONE.

   au_state_t        state_q;
   logic [CNT_W-1:0] nib_cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             op_q;
   logic             carry_reg_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_d;
   logic             carry_q;
   logic             ovf_q;
   logic             ovf_d;
   logic             zero_q;

   logic [NIBBLE_W-1:0] a_nib;
   logic [NIBBLE_W-1:0] b_nib;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;
   logic                last_nib;

   // Constant-index nibble mux keeps the selects static and lint-clean.
   always_comb begin
      a_nib    = '0;
      b_nib    = '0;
      result_d = result_q;
      for (int n = 0; n < NIB; n++) begin
         if (nib_cnt_q == CNT_W'(n)) begin
            a_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
            b_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
            result_d[n*NIBBLE_W +: NIBBLE_W] = slice_sum;
         end
      end
   end

   add_sub_4b u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry_reg_q),
      .ctrl (op_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   assign last_nib = (nib_cnt_q == CNT_W'(NIB - 1));

   // On the final step the top nibble comes straight from the slice.
   logic [WIDTH-1:0] result_fin;
   always_comb begin
      ovf_d      = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], op_q, slice_sum[NIBBLE_W-1]);
      result_fin = result_d;
`ifdef AU_SAT_EN
      if (ovf_d) begin
         result_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         nib_cnt_q   <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= OP_ADD;
         carry_reg_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q         <= a;
                  b_q         <= b;
                  op_q        <= op;
                  nib_cnt_q   <= '0;
                  carry_reg_q <= (op == OP_SUB);
                  state_q     <= RUN;
               end
            end
            RUN: begin
               carry_reg_q <= slice_cout;
               if (last_nib) begin
                  result_q <= result_fin;
                  carry_q  <= slice_cout;
                  ovf_q    <= ovf_d;
                  zero_q   <= (result_fin == '0);
                  state_q  <= DONE;
               end else begin
                  result_q  <= result_d;
                  nib_cnt_q <= nib_cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign result    = result_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub at WIDTH = 16.
// Expected values are hand-computed; AU_SAT_EN selects the clamped results.
module tb_nibble_serial_addsub;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         op = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         carry;
   logic         ovf;
   logic         zero;
   logic         busy;

   int n_cmp  = 0;
   int n_fail = 0;

   nibble_serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .ovf       (ovf),
      .zero      (zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", result); end
      n_cmp++; if ({carry, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {carry, ovf, zero}); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   // Issue one transaction, check latency, result and flags, then consume it.
   task automatic test_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic top, input logic [W-1:0] exp_res,
                          input logic exp_c, input logic exp_v, input logic exp_z);
      int guard;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_wait_ready got=%b exp=1", name, in_ready); end
      a = ta; b = tb_v; op = top; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; op = ~top;
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_run got=%b exp=1", name, busy); end
      for (int k = 1; k <= NIB; k++) begin
         if (k > 1) tick();
         if (k < NIB) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid k=%0d got=%b exp=0", name, k, out_valid); end
         end
      end
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency got=%b exp=1", name, out_valid); end
      n_cmp++; if (result !== exp_res) begin n_fail++; $display("FAIL %s_result got=%h exp=%h", name, result, exp_res); end
      n_cmp++; if (carry !== exp_c) begin n_fail++; $display("FAIL %s_carry got=%b exp=%b", name, carry, exp_c); end
      n_cmp++; if (ovf !== exp_v) begin n_fail++; $display("FAIL %s_ovf got=%b exp=%b", name, ovf, exp_v); end
      n_cmp++; if (zero !== exp_z) begin n_fail++; $display("FAIL %s_zero got=%b exp=%b", name, zero, exp_z); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drop_valid got=%b exp=0", name, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_back_idle got=%b exp=1", name, in_ready); end
   endtask

   // Hold DONE under backpressure, poke in_valid, then consume with in_valid high.
   task automatic test_backpressure();
      a = 16'h0003; b = 16'h0004; op = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < NIB; k++) tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
      for (int k = 0; k < 3; k++) begin
         in_valid = (k == 1);
         a = 16'h1111; b = 16'h2222;
         tick();
         n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid k=%0d got=%b exp=1", k, out_valid); end
         n_cmp++; if (result !== 16'h0007) begin n_fail++; $display("FAIL bp_hold_result k=%0d got=%h exp=0007", k, result); end
         n_cmp++; if ({carry, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL bp_hold_flags k=%0d got=%b exp=000", k, {carry, ovf, zero}); end
         n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, in_ready); end
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consume got=%b exp=0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_accept_in_done got=%b exp=1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy got=%b exp=0", busy); end
   endtask

   // Reset during the second RUN cycle must discard the transaction.
   task automatic test_reset_mid_run();
      int seen;
      seen = 0;
      a = 16'h1111; b = 16'h2222; op = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_run_idle got=%b exp=1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_run_valid got=%b exp=0", out_valid); end
      n_cmp++; if (result !== 16'h0000) begin n_fail++; $display("FAIL rst_run_result got=%h exp=0000", result); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_run_busy got=%b exp=0", busy); end
      for (int k = 0; k < 2 * NIB; k++) begin
         tick();
         if (out_valid === 1'b1) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_run_ghost got=%0d exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_op("add",     16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
      test_op("sub",     16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
`ifdef AU_SAT_EN
      test_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      test_op("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
      test_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      test_op("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
      test_op("zero",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      test_op("sub_eq",  16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      test_backpressure();
      test_reset_mid_run();
      test_op("post_rst", 16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
